pwm_dead_time: RTL and testbench

PWM_DEAD_TIME -- requirements
Module: pwm_dead_time

---
 rtl/pwm_dead_time.sv | 144 ++++++++++++++
 tb/tb_pwm_dead_time.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_dead_time.sv
// Complementary gate driver with programmable dead time, edge-swallowing and a sticky fault latch.
// The gates are registered from a one-hot view of the next state, so they can never overlap.
module pwm_dead_time #(
  parameter int unsigned DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            gate_hi,
  output logic            gate_lo,
  output logic            fault_latched,
  output logic            swallowed
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO_ON = 3'd1,
    S_DT_LH = 3'd2,
    S_HI_ON = 3'd3,
    S_DT_HL = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_pwm_q;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_cnt_nxt;
  logic            r_from_idle;
  logic            w_from_idle_nxt;
  logic            w_enter;
  logic            w_enter_hi;
  logic            w_swallow;
  logic            w_fault_nxt;
  logic            w_gate_hi_nxt;
  logic            w_gate_lo_nxt;

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pwm_q       <= 1'b0;
      r_cnt         <= '0;
      r_from_idle   <= 1'b0;
      gate_hi       <= 1'b0;
      gate_lo       <= 1'b0;
      fault_latched <= 1'b0;
      swallowed     <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_pwm_q       <= pwm_in;
      r_cnt         <= w_cnt_nxt;
      r_from_idle   <= w_from_idle_nxt;
      gate_hi       <= w_gate_hi_nxt;
      gate_lo       <= w_gate_lo_nxt;
      fault_latched <= w_fault_nxt;
      swallowed     <= w_swallow;
    end
  end

  // Next-state logic; fault beats enable, which beats normal sequencing
  always_comb begin
    w_next          = r_state;
    w_cnt_nxt       = r_cnt;
    w_from_idle_nxt = r_from_idle;
    w_enter         = 1'b0;
    w_enter_hi      = 1'b0;
    w_swallow       = 1'b0;
    w_fault_nxt     = fault | (fault_latched & ~fault_clr);

    if (fault || fault_latched || !en) begin
      w_next          = S_IDLE;
      w_cnt_nxt       = '0;
      w_from_idle_nxt = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_enter         = 1'b1;
          w_enter_hi      = r_pwm_q;
          w_from_idle_nxt = 1'b1;
        end
        S_LO_ON: begin
          w_enter         = r_pwm_q;
          w_enter_hi      = 1'b1;
          w_from_idle_nxt = 1'b0;
        end
        S_HI_ON: begin
          w_enter         = ~r_pwm_q;
          w_enter_hi      = 1'b0;
          w_from_idle_nxt = 1'b0;
        end
        S_DT_LH: begin
          if (!r_pwm_q && !r_from_idle) begin
            w_next    = S_LO_ON;
            w_cnt_nxt = '0;
            w_swallow = 1'b1;
          end else if (r_cnt <= DT_W'(1)) begin
            w_next    = S_HI_ON;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - DT_W'(1);
          end
        end
        S_DT_HL: begin
          if (r_pwm_q && !r_from_idle) begin
            w_next    = S_HI_ON;
            w_cnt_nxt = '0;
            w_swallow = 1'b1;
          end else if (r_cnt <= DT_W'(1)) begin
            w_next    = S_LO_ON;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt - DT_W'(1);
          end
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase

      // A zero dead time skips the dead state and swaps gates on one edge
      if (w_enter) begin
        w_cnt_nxt = dead_time;
        if (dead_time == '0) begin
          w_next = w_enter_hi ? S_HI_ON : S_LO_ON;
        end else begin
          w_next = w_enter_hi ? S_DT_LH : S_DT_HL;
        end
      end
    end
  end

  // Gate drives decoded from the next state
  always_comb begin
    w_gate_hi_nxt = 1'b0;
    w_gate_lo_nxt = 1'b0;
    if (w_next == S_HI_ON) w_gate_hi_nxt = 1'b1;
    if (w_next == S_LO_ON) w_gate_lo_nxt = 1'b1;
  end

endmodule

// File: tb/tb_pwm_dead_time.sv
// Bench for pwm_dead_time: per-cycle vectors with expected outputs queued at drive time
// and checked one edge later, plus a zero-dead-time square-wave sequence.
module tb_pwm_dead_time;

  typedef struct {
    logic       rst;
    logic       en;
    logic       pwm;
    logic [3:0] dt;
    logic       flt;
    logic       fclr;
    logic       ehi;
    logic       elo;
    logic       efl;
    logic       esw;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic [3:0] dead_time;
  logic       fault;
  logic       fault_clr;
  logic       gate_hi;
  logic       gate_lo;
  logic       fault_latched;
  logic       swallowed;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_step  = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  pwm_dead_time #(.DT_W(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .pwm_in        (pwm_in),
    .dead_time     (dead_time),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .gate_hi       (gate_hi),
    .gate_lo       (gate_lo),
    .fault_latched (fault_latched),
    .swallowed     (swallowed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int r, input int e, input int p, input int d,
                              input int f, input int c, input int h, input int l,
                              input int fl, input int s);
    vec_t v;
    v.rst = r[0];  v.en  = e[0];  v.pwm = p[0];  v.dt  = 4'(d);
    v.flt = f[0];  v.fclr = c[0]; v.ehi = h[0];  v.elo = l[0];
    v.efl = fl[0]; v.esw = s[0];
    return v;
  endfunction

  function automatic void add(input int n, input vec_t v);
    repeat (n) tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    en        = v.en;
    pwm_in    = v.pwm;
    dead_time = v.dt;
    fault     = v.flt;
    fault_clr = v.fclr;
    exp_q.push_back(v);
  endtask

  // Scoreboard: compare each queued expectation just after the edge that consumed its inputs
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      vec_t e;
      e = exp_q.pop_front();
      n_step++;
      n_tests++;
      if ({gate_hi, gate_lo, fault_latched, swallowed} !== {e.ehi, e.elo, e.efl, e.esw}) begin
        n_fail++;
        $display("FAIL step%0d hi/lo/flt/sw got %b%b%b%b want %b%b%b%b", n_step,
                 gate_hi, gate_lo, fault_latched, swallowed, e.ehi, e.elo, e.efl, e.esw);
      end
    end
    n_tests++;
    if (gate_hi === 1'b1 && gate_lo === 1'b1) begin
      n_fail++;
      $display("FAIL overlap at t=%0t got hi=%b lo=%b want not both 1", $time, gate_hi, gate_lo);
    end
  end

  initial begin
    int   n_a;
    logic p1;
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0; dead_time = 4'd0; fault = 1'b0; fault_clr = 1'b0;

    // Reset, startup from IDLE, rising command with dt=3
    add(1, mk(1,0,0,0,0,0, 0,0,0,0));
    add(3, mk(0,1,0,3,0,0, 0,0,0,0));
    add(2, mk(0,1,0,3,0,0, 0,1,0,0));
    add(1, mk(0,1,1,3,0,0, 0,1,0,0));
    add(3, mk(0,1,1,3,0,0, 0,0,0,0));
    add(2, mk(0,1,1,3,0,0, 1,0,0,0));
    // Back to LO_ON with dt=5, then a 2-cycle pulse that gets swallowed
    add(1, mk(0,1,0,5,0,0, 1,0,0,0));
    add(5, mk(0,1,0,5,0,0, 0,0,0,0));
    add(2, mk(0,1,0,5,0,0, 0,1,0,0));
    add(1, mk(0,1,1,5,0,0, 0,1,0,0));
    add(1, mk(0,1,1,5,0,0, 0,0,0,0));
    add(1, mk(0,1,0,5,0,0, 0,0,0,0));
    add(1, mk(0,1,0,5,0,0, 0,1,0,1));
    add(2, mk(0,1,0,5,0,0, 0,1,0,0));
    n_a = tbl.size();
    // Fault in HI_ON, ignored pwm activity, clear, re-entry through dead time
    add(1, mk(0,1,1,3,0,0, 0,1,0,0));
    add(3, mk(0,1,1,3,0,0, 0,0,0,0));
    add(1, mk(0,1,1,3,0,0, 1,0,0,0));
    add(1, mk(0,1,1,3,1,0, 0,0,1,0));
    add(1, mk(0,1,0,3,0,0, 0,0,1,0));
    add(1, mk(0,1,1,3,0,0, 0,0,1,0));
    add(1, mk(0,1,0,3,0,0, 0,0,1,0));
    add(1, mk(0,1,1,3,0,1, 0,0,0,0));
    add(3, mk(0,1,1,3,0,0, 0,0,0,0));
    add(1, mk(0,1,1,3,0,0, 1,0,0,0));
    // fault and fault_clr together: fault wins
    add(1, mk(0,1,1,3,1,1, 0,0,1,0));
    add(1, mk(0,1,1,3,0,0, 0,0,1,0));
    add(1, mk(0,1,1,3,0,1, 0,0,0,0));
    // Reverting command during an IDLE-entered dead period still completes it
    add(3, mk(0,1,0,3,0,0, 0,0,0,0));
    add(1, mk(0,1,0,3,0,0, 1,0,0,0));
    add(1, mk(0,1,0,3,0,0, 0,0,0,0));
    add(2, mk(0,0,1,3,0,0, 0,0,0,0));
    // Reset mid DT_LH with dt=7, then a full 7-cycle dead period before any gate
    add(2, mk(0,1,1,7,0,0, 0,0,0,0));
    add(1, mk(1,1,1,7,0,0, 0,0,0,0));
    add(7, mk(0,1,1,7,0,0, 0,0,0,0));
    add(1, mk(0,1,1,7,0,0, 0,1,0,0));
    add(1, mk(0,1,1,7,0,0, 0,0,0,0));
    // dead_time 2 -> 6 during DT_HL: current period stays 2, next one is 6
    add(1, mk(1,1,0,2,0,0, 0,0,0,0));
    add(2, mk(0,1,0,2,0,0, 0,0,0,0));
    add(1, mk(0,1,0,2,0,0, 0,1,0,0));
    add(1, mk(0,1,1,2,0,0, 0,1,0,0));
    add(2, mk(0,1,1,2,0,0, 0,0,0,0));
    add(1, mk(0,1,1,2,0,0, 1,0,0,0));
    add(1, mk(0,1,0,2,0,0, 1,0,0,0));
    add(1, mk(0,1,0,2,0,0, 0,0,0,0));
    add(1, mk(0,1,0,6,0,0, 0,0,0,0));
    add(1, mk(0,1,0,6,0,0, 0,1,0,0));
    add(1, mk(0,1,1,6,0,0, 0,1,0,0));
    add(6, mk(0,1,1,6,0,0, 0,0,0,0));
    add(2, mk(0,1,1,6,0,0, 1,0,0,0));
    add(1, mk(0,0,1,6,0,0, 0,0,0,0));

    for (int i = 0; i < n_a; i++) drive(tbl[i]);

    // dt=0 square wave, period 10: gates follow the command one cycle late, no dead gap
    p1 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic p;
      p = ((i / 5) % 2) == 0;
      drive(mk(0, 1, int'(p), 0, 0, 0, int'(p1), int'(!p1), 0, 0));
      p1 = p;
    end

    for (int i = n_a; i < tbl.size(); i++) drive(tbl[i]);

    repeat (2) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
